tsc_capture: RTL and testbench

- Transient storage controller: the initiator side of the req/rdy/dat ADC handshake.
- Repeatedly requests 8-bit samples and keeps a pre-trigger history in a circular buffer.
- Freezes capture a programmable number of samples after the first sample at or above a threshold.
- Then lets a host drain the stored record oldest-first. Sits between the ADC and the host readout logic.

---
 rtl/tsc_capture.sv | 144 ++++++++++++++
 tb/tb_tsc_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tsc_capture.sv
// Transient storage controller: drives the four-phase req/rdy ADC handshake,
// keeps a circular pre-trigger history and lets a host drain the frozen record.
module tsc_capture #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [AW-1:0]     post_cnt,
  output logic              req,
  input  logic              rdy,
  input  logic [DATA_W-1:0] dat,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              trig_hit,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, ACK, RELEASE, READOUT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] lvl;
  logic [AW-1:0]     post_lat;
  logic [AW-1:0]     post_left;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       fill;
  logic [AW:0]       rd_left;
  logic [TW-1:0]     tmo_cnt;

  // Sample storage needs no reset; contents are only read after a completed capture.
  always_ff @(posedge clk) begin
    if (state == ACK && rdy) mem[wr_ptr] <= dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      trig_hit    <= 1'b0;
      timeout_err <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      lvl         <= '0;
      post_lat    <= '0;
      post_left   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      rd_left     <= '0;
      tmo_cnt     <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // post_cnt is AW bits wide, so it can never exceed DEPTH-1.
          lvl         <= trig_level;
          post_lat    <= post_cnt;
          wr_ptr      <= '0;
          fill        <= '0;
          post_left   <= '0;
          trig_hit    <= 1'b0;
          timeout_err <= 1'b0;
          req         <= 1'b1;
          busy        <= 1'b1;
          state       <= REQ;
        end
        REQ: begin
          tmo_cnt <= '0;
          state   <= ACK;
        end
        ACK: begin
          if (rdy) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (fill != FULL) fill <= fill + (AW+1)'(1);
            if (!trig_hit && dat >= lvl) begin
              trig_hit  <= 1'b1;
              post_left <= post_lat;
            end else if (trig_hit) begin
              post_left <= post_left - AW'(1);
            end
            req     <= 1'b0;
            tmo_cnt <= '0;
            state   <= RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            req         <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RELEASE: begin
          if (!rdy) begin
            if (trig_hit && post_left == '0) begin
              // A full buffer has wrapped, so the oldest entry sits at wr_ptr.
              rd_ptr  <= (fill == FULL) ? wr_ptr : '0;
              rd_left <= fill;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= READOUT;
            end else begin
              req   <= 1'b1;
              state <= REQ;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        READOUT: if (rd_en) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + AW'(1);
          rd_left  <= rd_left - (AW+1)'(1);
          if (rd_left == (AW+1)'(1)) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsc_capture.sv
// Scoreboard bench for tsc_capture: a scripted ADC answers the handshake,
// expected pops are queued up front and a monitor checks every rd_valid.
module tb_tsc_capture;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 15;
  localparam int AW      = $clog2(DEPTH);

  logic              clk, rst, start, req, rdy, rd_en, rd_valid, busy, done, trig_hit, timeout_err;
  logic [DATA_W-1:0] trig_level, dat, rd_data;
  logic [AW-1:0]     post_cnt;

  tsc_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .trig_level(trig_level), .post_cnt(post_cnt),
    .req(req), .rdy(rdy), .dat(dat), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .trig_hit(trig_hit),
    .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] adc_q[$];
  int adc_idx  = 0;
  int adc_mode = 0;  // 0 scripted samples, 1 never ready, 2 ready stuck high
  int req_rises = 0;
  logic req_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ADC model: reacts to req just after each rising edge.
  initial begin
    rdy = 1'b0;
    dat = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) rdy = 1'b0;
      else if (adc_mode == 0) begin
        if (req && !rdy && adc_idx < adc_q.size()) begin
          dat = adc_q[adc_idx];
          adc_idx++;
          rdy = 1'b1;
        end else if (!req && rdy) rdy = 1'b0;
      end else if (adc_mode == 1) rdy = 1'b0;
      else if (req && !rdy) begin
        dat = 8'hAA;
        rdy = 1'b1;
      end
    end
  end

  // Monitor: every rd_valid must match the head of the scoreboard.
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (req && !req_prev) req_rises++;
      req_prev = req;
      if (rd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop: got rd_data=%0d, expected no rd_valid", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL pop_data: got %0d, expected %0d", rd_data, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [DATA_W-1:0] lvl, input logic [AW-1:0] pc);
    trig_level = lvl;
    post_cnt   = pc;
    start      = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic load_adc(input int mode);
    adc_q.delete();
    adc_idx  = 0;
    adc_mode = mode;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    chk(name, done, 1);
  endtask

  task automatic pop_all(input string name, input int n, input bit hold);
    int vcnt = 0;
    if (done !== 1'b1) return;
    if (hold) begin
      rd_en = 1'b1;
      for (int i = 0; i < n; i++) begin
        tick(1);
        if (rd_valid) vcnt++;
      end
      rd_en = 1'b0;
      chk({name, "_consecutive"}, vcnt, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (i != n - 1) tick(1);
      end
    end
    chk({name, "_last_valid"}, rd_valid, 1);
    chk({name, "_done_fell"}, done, 0);
    tick(2);
    chk({name, "_all_popped"}, exp_q.size(), 0);
    chk({name, "_trig_hit"}, trig_hit, 1);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; rd_en = 1'b0; trig_level = '0; post_cnt = '0;
    tick(2);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_flags", {trig_hit, timeout_err}, 0);
    rst = 1'b0;
    tick(1);

    // rd_en in IDLE is ignored
    rd_en = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin tick(1); if (rd_valid) n++; end
    rd_en = 1'b0;
    chk("idle_rd_en", n, 0);

    // Basic capture, with a stray start while busy
    load_adc(0);
    for (int i = 1; i <= 13; i++) begin adc_q.push_back(8'(i * 10)); exp_q.push_back(8'(i * 10)); end
    pulse_start(8'd100, 5'd3);
    tick(6);
    pulse_start(8'd0, 5'd0);
    wait_done("basic_done");
    chk("basic_fill_used", adc_idx, 13);
    pop_all("basic", 13, 1'b0);

    // Wrap-around: 55 samples into 32 entries
    load_adc(0);
    for (int i = 0; i < 50; i++) adc_q.push_back(8'(i));
    for (int i = 200; i <= 204; i++) adc_q.push_back(8'(i));
    for (int i = 23; i < 50; i++) exp_q.push_back(8'(i));
    for (int i = 200; i <= 204; i++) exp_q.push_back(8'(i));
    pulse_start(8'd200, 5'd4);
    wait_done("wrap_done");
    pop_all("wrap", 32, 1'b0);

    // Immediate trigger: one handshake, one pop
    load_adc(0);
    adc_q.push_back(8'd77);
    exp_q.push_back(8'd77);
    req_rises = 0;
    pulse_start(8'd0, 5'd0);
    wait_done("imm_done");
    pop_all("imm", 1, 1'b0);
    tick(6);
    chk("imm_req_pulses", req_rises, 1);

    // Timeout in ACK: req high for the REQ cycle plus TIMEOUT ACK cycles
    load_adc(1);
    pulse_start(8'd50, 5'd2);
    n = 0;
    while (req && n < 100) begin n++; tick(1); end
    chk("tmo_ack_req_cycles", n, 1 + TIMEOUT);
    chk("tmo_ack_err", timeout_err, 1);
    chk("tmo_ack_idle", {busy, done}, 0);

    // Timeout in RELEASE: rdy never drops
    load_adc(2);
    pulse_start(8'd255, 5'd5);
    n = 0;
    while (busy && n < 100) begin n++; tick(1); end
    chk("tmo_rel_busy_cycles", n, 2 + TIMEOUT);
    chk("tmo_rel_err", timeout_err, 1);
    chk("tmo_rel_req", req, 0);
    load_adc(0);
    tick(3);

    // Next start clears timeout_err; reset mid-handshake drops req at once
    load_adc(1);
    pulse_start(8'd100, 5'd3);
    chk("tmo_cleared", timeout_err, 0);
    tick(4);
    chk("ack_req_high", req, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", req, 0);
    chk("midrst_outs", {busy, done, rd_valid, trig_hit, timeout_err}, 0);
    chk("midrst_rd_data", rd_data, 0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // post_cnt at DEPTH-1: trigger sample becomes the oldest entry
    load_adc(0);
    for (int i = 1; i <= 4; i++) adc_q.push_back(8'(i));
    adc_q.push_back(8'd250);
    exp_q.push_back(8'd250);
    for (int i = 0; i < 31; i++) begin adc_q.push_back(8'(i)); exp_q.push_back(8'(i)); end
    pulse_start(8'd200, 5'd31);
    wait_done("clamp_done");
    chk("clamp_samples", adc_idx, 36);
    pop_all("clamp", 32, 1'b1);

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
